// File: rtl/binary_decoder38_seq.sv
// binary_decoder38_seq: registered 3-to-8 decoder with handshake and optional one-hot sweep (BINARY_DECODER_SWEEP_EN).
module binary_decoder38_seq #(
  parameter int SWEEP_DWELL = 1,
  parameter int DWELL_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       En,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] a,
  input  logic       sweep_start,
  output logic [7:0] q,
  output logic       q_valid,
  output logic       busy,
  output logic       sweep_done
);
`ifdef BINARY_DECODER_SWEEP_EN
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state;
  logic [DWELL_W-1:0] cnt;
  assign in_ready = En && state == IDLE;
  assign busy = state == SWEEP;
  // q itself is the sweep index: the walk ends once bit 7 has dwelt its full time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      q <= '0;
      q_valid <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      q_valid <= 1'b0;
      sweep_done <= 1'b0;
      if (!En) begin
        state <= IDLE;
        cnt <= '0;
        q <= '0;
      end else if (state == IDLE) begin
        if (in_valid) begin
          q <= 8'b1 << a;
          q_valid <= 1'b1;
        end else if (sweep_start) begin
          state <= SWEEP;
          cnt <= '0;
          q <= 8'h01;
          q_valid <= 1'b1;
        end
      end else if (cnt == DWELL_W'(SWEEP_DWELL - 1)) begin
        cnt <= '0;
        if (q[7]) begin
          state <= IDLE;
          sweep_done <= 1'b1;
        end else begin
          q <= {q[6:0], 1'b0};
          q_valid <= 1'b1;
        end
      end else begin
        cnt <= cnt + DWELL_W'(1);
      end
    end
  end
`else
  logic unused_sweep;
  assign unused_sweep = sweep_start;
  assign in_ready = En;
  assign busy = 1'b0;
  assign sweep_done = 1'b0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
      q_valid <= 1'b0;
    end else begin
      q <= !En ? 8'h00 : in_valid ? 8'b1 << a : q;
      q_valid <= En && in_valid;
    end
  end
`endif
endmodule
